// File: rtl/buzzer_arbiter_pkg.sv
// Shared definitions for the buzzer arbiter slice.
// Contents: mode encodings, requester indices, the rest note code, the arbiter
// state encoding, and a helper that maps a mode to the requesters it allows.
package buzzer_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_MENU = 2'b00,
    MODE_FREE = 2'b01,
    MODE_AUTO = 2'b10,
    MODE_LERN = 2'b11
  } mode_e;

  localparam int REQ_FREE = 0;
  localparam int REQ_AUTO = 1;
  localparam int REQ_LERN = 2;
  localparam int NUM_REQ  = 3;

  localparam int NOTE_REST = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Requesters that the given mode lets onto the buzzer.
  // LERN mode also admits FREE so the player can play along.
  function automatic logic [NUM_REQ-1:0] mode_mask(input logic [1:0] mode);
    logic [NUM_REQ-1:0] m;
    m = '0;
    case (mode)
      MODE_FREE: m[REQ_FREE] = 1'b1;
      MODE_AUTO: m[REQ_AUTO] = 1'b1;
      MODE_LERN: begin
        m[REQ_LERN] = 1'b1;
        m[REQ_FREE] = 1'b1;
      end
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/buzzer_arbiter_if.sv
// Bus between the note sources / mode FSM and the buzzer arbiter.
// Signals:
//   mode     mode FSM state (MENU/FREE/AUTO/LERN)
//   req      per-requester note request, [0] FREE, [1] AUTO, [2] LERN
//   note_in  per-requester note code, slice i = requester i
//   grant    one-hot current owner
//   note_out note to the tone generator
//   note_vld tone generator enable
//   busy     arbiter not idle
// Modports: master = sources side, slave = arbiter side.
interface buzzer_arbiter_if #(
  parameter int NOTE_W = 4
);
  logic [1:0]          mode;
  logic [2:0]          req;
  logic [3*NOTE_W-1:0] note_in;
  logic [2:0]          grant;
  logic [NOTE_W-1:0]   note_out;
  logic                note_vld;
  logic                busy;

  modport master (
    output mode, req, note_in,
    input  grant, note_out, note_vld, busy
  );

  modport slave (
    input  mode, req, note_in,
    output grant, note_out, note_vld, busy
  );
endinterface

// File: rtl/buzzer_arb_pick.sv
// Combinational owner selection for the buzzer arbiter.
// Ports:
//   elig          eligible requesters (req gated by mode)
//   rr_ptr        round-robin start index (used only with BUZZER_ARB_RR_EN)
//   owner         current one-hot owner, 0 when none
//   winner        one-hot selected requester, 0 when none eligible
//   hipri_pending an eligible requester outranks the still-eligible owner
// Build option BUZZER_ARB_RR_EN: round-robin in order FREE->AUTO->LERN and
// no preemption; otherwise fixed priority FREE > LERN > AUTO.
module buzzer_arb_pick
  import buzzer_arbiter_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] rr_ptr,
  input  logic [2:0] owner,
  output logic [2:0] winner,
  output logic       hipri_pending
);

`ifdef BUZZER_ARB_RR_EN
  always_comb begin
    winner = '0;
    case (rr_ptr)
      2'd1: begin
        if      (elig[REQ_AUTO]) winner[REQ_AUTO] = 1'b1;
        else if (elig[REQ_LERN]) winner[REQ_LERN] = 1'b1;
        else if (elig[REQ_FREE]) winner[REQ_FREE] = 1'b1;
      end
      2'd2: begin
        if      (elig[REQ_LERN]) winner[REQ_LERN] = 1'b1;
        else if (elig[REQ_FREE]) winner[REQ_FREE] = 1'b1;
        else if (elig[REQ_AUTO]) winner[REQ_AUTO] = 1'b1;
      end
      default: begin
        if      (elig[REQ_FREE]) winner[REQ_FREE] = 1'b1;
        else if (elig[REQ_AUTO]) winner[REQ_AUTO] = 1'b1;
        else if (elig[REQ_LERN]) winner[REQ_LERN] = 1'b1;
      end
    endcase
  end

  // Round-robin owners are never preempted.
  assign hipri_pending = 1'b0;

  logic unused_owner;
  assign unused_owner = ^owner;
`else
  always_comb begin
    winner = '0;
    if      (elig[REQ_FREE]) winner[REQ_FREE] = 1'b1;
    else if (elig[REQ_LERN]) winner[REQ_LERN] = 1'b1;
    else if (elig[REQ_AUTO]) winner[REQ_AUTO] = 1'b1;
  end

  // The winner is the top-ranked eligible requester, so if the owner is still
  // eligible and did not win, something of higher rank is waiting.
  assign hipri_pending = (|(elig & owner)) && (winner != owner);

  logic unused_rr;
  assign unused_rr = ^rr_ptr;
`endif

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: shares the single tone path between the FREE, AUTO and
// LERN note sources. Gates requests by mode, picks one owner, enforces a
// minimum note hold and a silent gap on every owner release.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  buzzer_arbiter_if.slave (mode, req, note_in in; grant, note_out,
//        note_vld, busy out; all outputs registered)
// Build option BUZZER_ARB_RR_EN selects round-robin picking (see buzzer_arb_pick).
//
// state | meaning
// IDLE  | no owner, arbitrates eligible requests every cycle
// PLAY  | owner drives the buzzer, hold counter running
// GAP   | silent spacer after a release, counts gap_cnt down to 0
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter int NOTE_W       = 4,
  parameter int MIN_HOLD_CYC = 2_000_000,
  parameter int GAP_CYC      = 500_000,
  parameter int CNT_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  buzzer_arbiter_if.slave  bus
);

  arb_state_e        state;
  logic [2:0]        grant_q;
  logic [NOTE_W-1:0] note_q;
  logic              vld_q;
  logic              busy_q;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  gap_cnt;
  logic [1:0]        rr_ptr;

  logic [2:0]        elig;
  logic [2:0]        winner;
  logic              hipri_pending;
  logic              own_req;
  logic              own_ok;
  logic              hold_done;
  logic              leave_play;
  logic [NOTE_W-1:0] win_note;
  logic [NOTE_W-1:0] own_note;

  assign elig    = bus.req & mode_mask(bus.mode);
  assign own_req = |(grant_q & bus.req);
  assign own_ok  = |(grant_q & mode_mask(bus.mode));

  // hold_cnt counts PLAY edges after the grant edge, so comparing hold_cnt+1
  // keeps note_vld high for exactly MIN_HOLD_CYC cycles on a short press.
  assign hold_done = ({1'b0, hold_cnt} + 1'b1) >= (CNT_W+1)'(MIN_HOLD_CYC);

  // Mode loss releases at once; otherwise release needs the hold, then either
  // the owner letting go or a higher-ranked requester waiting.
  assign leave_play = !own_ok || (hold_done && (!own_req || hipri_pending));

  buzzer_arb_pick u_pick (
    .elig          (elig),
    .rr_ptr        (rr_ptr),
    .owner         (grant_q),
    .winner        (winner),
    .hipri_pending (hipri_pending)
  );

  always_comb begin
    win_note = '0;
    own_note = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i])  win_note = bus.note_in[i*NOTE_W +: NOTE_W];
      if (grant_q[i]) own_note = bus.note_in[i*NOTE_W +: NOTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_q  <= '0;
      note_q   <= NOTE_W'(NOTE_REST);
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      rr_ptr   <= 2'(REQ_FREE);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            state    <= ST_PLAY;
            grant_q  <= winner;
            note_q   <= win_note;
            vld_q    <= 1'b1;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
            rr_ptr   <= winner[REQ_FREE] ? 2'(REQ_AUTO) :
                        winner[REQ_AUTO] ? 2'(REQ_LERN) : 2'(REQ_FREE);
          end
        end
        ST_PLAY: begin
          if (hold_cnt < CNT_W'(MIN_HOLD_CYC)) hold_cnt <= hold_cnt + 1'b1;
          if (leave_play) begin
            state   <= ST_GAP;
            grant_q <= '0;
            note_q  <= NOTE_W'(NOTE_REST);
            vld_q   <= 1'b0;
            gap_cnt <= CNT_W'(GAP_CYC);
          end else if (own_req) begin
            note_q <= own_note;
          end
        end
        ST_GAP: begin
          // A load of 0 or 1 both give a single gap cycle.
          if (gap_cnt <= CNT_W'(1)) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          note_q  <= NOTE_W'(NOTE_REST);
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.note_out = note_q;
  assign bus.note_vld = vld_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Testbench for buzzer_arbiter with MIN_HOLD_CYC=4, GAP_CYC=2.
// Stimulus pushes the expected output change (cycle, grant, note, vld, busy)
// into a scoreboard queue; a monitor pops one entry on every output change.
module tb_buzzer_arbiter;
  import buzzer_arbiter_pkg::*;

  localparam int NOTE_W = 4;

  typedef struct {
    int         cyc;
    logic [2:0] grant;
    logic [3:0] note;
    logic       vld;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  logic [8:0] prev_o = '0;

  buzzer_arbiter_if #(.NOTE_W(NOTE_W)) bus ();

  buzzer_arbiter #(
    .NOTE_W       (NOTE_W),
    .MIN_HOLD_CYC (4),
    .GAP_CYC      (2),
    .CNT_W        (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) tick();
  endtask

  task automatic set_note(input int idx, input logic [3:0] v);
    bus.note_in[idx*NOTE_W +: NOTE_W] = v;
  endtask

  task automatic exp_ev(input int at, input logic [2:0] g, input logic [3:0] n,
                        input logic v, input logic b);
    exp_t e;
    e.cyc = at; e.grant = g; e.note = n; e.vld = v; e.busy = b;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [8:0] cur_o;
    exp_t e;
    if (mon_en) begin
      cur_o = {bus.grant, bus.note_out, bus.note_vld, bus.busy};
      if (cur_o !== prev_o) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got grant=%b note=%0d vld=%b busy=%b, required no change",
                   cyc, bus.grant, bus.note_out, bus.note_vld, bus.busy);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.grant !== bus.grant || e.note !== bus.note_out ||
              e.vld !== bus.note_vld || e.busy !== bus.busy) begin
            n_fail++;
            $display("FAIL event got cyc=%0d grant=%b note=%0d vld=%b busy=%b, required cyc=%0d grant=%b note=%0d vld=%b busy=%b",
                     cyc, bus.grant, bus.note_out, bus.note_vld, bus.busy,
                     e.cyc, e.grant, e.note, e.vld, e.busy);
          end
        end
        prev_o = cur_o;
      end
    end
  end

  initial begin
    int b;
    rst = 1'b1;
    bus.mode = MODE_MENU;
    bus.req = '0;
    bus.note_in = '0;
    repeat (3) tick();

    @(negedge clk);
    n_tests++;
    if (bus.grant !== 3'b000 || bus.note_out !== 4'd0 || bus.note_vld !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got grant=%b note=%0d vld=%b busy=%b, required all 0",
               bus.grant, bus.note_out, bus.note_vld, bus.busy);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    tick();

    // 1: FREE short press, held for the minimum then gapped
    b = cyc;
    bus.mode = MODE_FREE; set_note(REQ_FREE, 4'd3); bus.req = 3'b001;
    exp_ev(b+1, 3'b001, 4'd3, 1'b1, 1'b1);
    exp_ev(b+5, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+7, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+1);
    bus.req = 3'b000;
    wait_until(b+10);

    // 2: AUTO mode ignores FREE; owner note 0 keeps vld high
    b = cyc;
    bus.mode = MODE_AUTO; set_note(REQ_AUTO, 4'd9); set_note(REQ_FREE, 4'd3);
    bus.req = 3'b011;
    exp_ev(b+1, 3'b010, 4'd9, 1'b1, 1'b1);
    wait_until(b+2);
    set_note(REQ_AUTO, 4'd0);
    exp_ev(b+3, 3'b010, 4'd0, 1'b1, 1'b1);
    wait_until(b+5);
    bus.req = 3'b000;
    exp_ev(b+6, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+8, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+11);

    // 3: LERN owns, FREE arrives mid-hold
    b = cyc;
    bus.mode = MODE_LERN; set_note(REQ_LERN, 4'd12); set_note(REQ_FREE, 4'd3);
    bus.req = 3'b100;
    exp_ev(b+1, 3'b100, 4'd12, 1'b1, 1'b1);
    wait_until(b+2);
    bus.req = 3'b101;
`ifdef BUZZER_ARB_RR_EN
    wait_until(b+6);
    bus.req = 3'b001;
    exp_ev(b+7,  3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+9,  3'b000, 4'd0, 1'b0, 1'b0);
    exp_ev(b+10, 3'b001, 4'd3, 1'b1, 1'b1);
    wait_until(b+10);
    bus.req = 3'b000;
    exp_ev(b+14, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+16, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+19);
`else
    exp_ev(b+5, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+7, 3'b000, 4'd0, 1'b0, 1'b0);
    exp_ev(b+8, 3'b001, 4'd3, 1'b1, 1'b1);
    wait_until(b+8);
    bus.req = 3'b000;
    exp_ev(b+12, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+14, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+17);
`endif

    // 4: mode change to MENU releases at once, no regrant
    b = cyc;
    bus.mode = MODE_FREE; set_note(REQ_FREE, 4'd5); bus.req = 3'b001;
    exp_ev(b+1, 3'b001, 4'd5, 1'b1, 1'b1);
    wait_until(b+1);
    bus.mode = MODE_MENU;
    exp_ev(b+2, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+4, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+8);
    bus.req = 3'b000;
    wait_until(b+10);

    // 5: reset mid-PLAY, regrant once released
    b = cyc;
    bus.mode = MODE_FREE; set_note(REQ_FREE, 4'd7); bus.req = 3'b001;
    exp_ev(b+1, 3'b001, 4'd7, 1'b1, 1'b1);
    wait_until(b+2);
    rst = 1'b1;
    exp_ev(b+3, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+3);
    rst = 1'b0;
    exp_ev(b+4, 3'b001, 4'd7, 1'b1, 1'b1);
    wait_until(b+4);
    bus.req = 3'b000;
    exp_ev(b+8,  3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+10, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+13);

    // 6: note follows owner, hold not restarted, note frozen after release
    b = cyc;
    set_note(REQ_FREE, 4'd3); bus.req = 3'b001;
    exp_ev(b+1, 3'b001, 4'd3, 1'b1, 1'b1);
    wait_until(b+2);
    set_note(REQ_FREE, 4'd6);
    exp_ev(b+3, 3'b001, 4'd6, 1'b1, 1'b1);
    wait_until(b+3);
    bus.req = 3'b000; set_note(REQ_FREE, 4'd1);
    exp_ev(b+5, 3'b000, 4'd0, 1'b0, 1'b1);
    exp_ev(b+7, 3'b000, 4'd0, 1'b0, 1'b0);
    wait_until(b+10);

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got %0d pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
